// File: rtl/led_scan_display_pkg.sv
// Shared constants for the multiplexed six-digit LED scanner:
// segment bit positions, the BCD glyph table and the blink period.
package led_scan_display_pkg;

   // Bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} segment bus
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam int NUM_DIGITS = 6;

   // Frames per blink half-period and the width of the counter that times it
   localparam int BLINK_FRAMES = 64;
   localparam int BLINK_CNT_W  = $clog2(BLINK_FRAMES);

   // Code -> active-high {g,f,e,d,c,b,a}; A..E show a dash, F is blank.
   // Listed from code 15 down to code 0.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'h00,                                   // F blank
      7'h40, 7'h40, 7'h40, 7'h40, 7'h40,       // E..A dash
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,       // 9..5
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F        // 4..0
   };

endpackage

// File: rtl/led_scan_display_decode.sv
// Combinational BCD to seven-segment decoder (active-high pattern out).
module seg7_decode
   import led_scan_display_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] pattern
);

   // Pure table lookup; polarity is handled at the scanner's output register
   assign pattern = GLYPH_TABLE[code];

endmodule

// File: rtl/led_scan_display.sv
// Six-digit time-multiplexed LED display scanner.
// Digits are shown from a per-frame snapshot so updates never tear mid-frame.
// Optional feature: define LED_SCAN_DISPLAY_BLINK_EN to add blink_mask and
// the 64-frame blink phase (blinking digits keep their anode, segments off).
module led_scan_display
   import led_scan_display_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit5,
   input  logic [3:0] digit4,
   input  logic [3:0] digit3,
   input  logic [3:0] digit2,
   input  logic [3:0] digit1,
   input  logic [3:0] digit0,
   input  logic [5:0] dp_mask,
`ifdef LED_SCAN_DISPLAY_BLINK_EN
   input  logic [5:0] blink_mask,
`endif
   output logic [7:0] seg,
   output logic [5:0] an
);

   localparam int              PW         = $clog2(SCAN_DIV);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0]   BLANK_END  = PW'(BLANK_CYCLES);
   localparam logic [2:0]      LAST_SLOT  = 3'(NUM_DIGITS - 1);
   localparam logic [7:0]      SEG_POL    = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [5:0]      AN_POL     = (ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

   logic [PW-1:0]   presc;
   logic [2:0]      slot;
   logic [5:0][3:0] snap_digit;
   logic [5:0]      snap_dp;
   logic            load_pend;
   logic            slot_wrap;
   logic            frame_end;
   logic            blanking;
   logic [6:0]      pattern;
   logic [7:0]      seg_act;
   logic [5:0]      an_act;

   assign slot_wrap = (presc == PRESC_LAST);
   assign frame_end = slot_wrap && (slot == LAST_SLOT);
   assign blanking  = (presc < BLANK_END);

   // Prescaler and slot index; slot steps 0..5 once per prescaler wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         slot  <= '0;
      end else if (slot_wrap) begin
         presc <= '0;
         slot  <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Snapshot capture at each frame boundary; the first cycle out of reset
   // counts as one so the display never starts from stale blank digits
   always_ff @(posedge clk) begin
      if (reset) begin
         snap_digit <= {NUM_DIGITS{4'hF}};
         snap_dp    <= '0;
         load_pend  <= 1'b1;
      end else begin
         load_pend <= 1'b0;
         if (load_pend || frame_end) begin
            snap_digit <= {digit5, digit4, digit3, digit2, digit1, digit0};
            snap_dp    <= dp_mask;
         end
      end
   end

`ifdef LED_SCAN_DISPLAY_BLINK_EN
   logic [5:0]             snap_blink;
   logic [BLINK_CNT_W-1:0] frame_cnt;
   logic                   blink_phase;

   // Blink mask snapshot plus frame counter; phase flips every BLINK_FRAMES frames
   always_ff @(posedge clk) begin
      if (reset) begin
         snap_blink  <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         if (load_pend || frame_end)
            snap_blink <= blink_mask;
         if (frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (frame_cnt == BLINK_CNT_W'(BLINK_FRAMES - 1))
               blink_phase <= ~blink_phase;
         end
      end
   end
`endif

   seg7_decode u_decode (
      .code    (snap_digit[slot]),
      .pattern (pattern)
   );

   // Active-high drive for the current slot; everything dark while blanking
   always_comb begin
      an_act  = '0;
      seg_act = '0;
      if (!blanking) begin
         an_act[slot]           = 1'b1;
         seg_act[SEG_G:SEG_A]   = pattern;
         seg_act[SEG_DP]        = snap_dp[slot];
`ifdef LED_SCAN_DISPLAY_BLINK_EN
         if (blink_phase && snap_blink[slot])
            seg_act = '0;
`endif
      end
   end

   // Output register; polarity is applied only here
   always_ff @(posedge clk) begin
      if (reset) begin
         seg <= SEG_POL;
         an  <= AN_POL;
      end else begin
         seg <= seg_act ^ SEG_POL;
         an  <= an_act ^ AN_POL;
      end
   end

endmodule
